data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 29 ++
 rtl/data_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a requester and the data memory controller.
// The master modport is the requester side; the slave modport is the controller side.
interface data_mem_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port word memory with byte-strobed writes, 1-cycle registered reads,
// out-of-range error responses and a self-initialising sweep after reset or clear.
module data_mem_ctrl #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       DEPTH  = 256,
  parameter logic [DATA_W-1:0] INIT0  = '1,
  parameter logic [DATA_W-1:0] INIT1  = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  output logic           busy,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_ready_c;
  logic              accept_c;
  logic              in_range_c;
  logic              wr_en_c;
  logic [MEM_AW-1:0] mem_addr_c;
  logic [MEM_AW-1:0] sweep_addr_c;
  logic [DATA_W-1:0] sweep_data_c;

  // Backpressure: a new request only when the response slot is free or draining.
  assign req_ready_c  = (state_q == ST_READY) && (!rsp_valid_q || bus.rsp_ready);
  assign accept_c     = bus.req_valid && req_ready_c;
  assign in_range_c   = IDX_W'(bus.req_addr) < DEPTH_IDX;
  assign wr_en_c      = accept_c && bus.req_write && in_range_c;
  assign mem_addr_c   = MEM_AW'(bus.req_addr);
  assign sweep_addr_c = MEM_AW'(idx_q);

  always_comb begin
    sweep_data_c = '0;
    if (idx_q == '0) begin
      sweep_data_c = INIT0;
    end else if (idx_q == IDX_W'(1)) begin
      sweep_data_c = INIT1;
    end
  end

  // Next-state, sweep index and response slot.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_INIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        if (clear) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase

    if (accept_c && !bus.req_write) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = in_range_c ? mem[mem_addr_c] : '0;
      rsp_err_d   = !in_range_c;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage has no reset; its contents come only from the sweep and writes.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem[sweep_addr_c] <= sweep_data_c;
    end else if (wr_en_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.req_wstrb[b]) begin
          mem[mem_addr_c][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign busy          = (state_q == ST_INIT);
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a default 8-bit instance and a 32-bit, 200-word instance,
// with expected read responses queued at request time and popped as responses arrive.
module tb_data_mem_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic busy_a;
  logic busy_b;

  data_mem_ctrl_if #(.DATA_W(8),  .ADDR_W(8)) ia ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(8)) ib ();

  data_mem_ctrl u_dut_a (
    .clock (clk),
    .reset (rst_n),
    .clear (clr_a),
    .busy  (busy_a),
    .bus   (ia)
  );

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u_dut_b (
    .clock (clk),
    .reset (rst_n),
    .clear (clr_b),
    .busy  (busy_b),
    .bus   (ib)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0]  q_a [$];
  logic [32:0] q_b [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    ia.req_valid = 1'b0; ia.req_write = 1'b0; ia.req_addr = '0;
    ia.req_wdata = '0;   ia.req_wstrb = '0;   ia.rsp_ready = 1'b1;
    ib.req_valid = 1'b0; ib.req_write = 1'b0; ib.req_addr = '0;
    ib.req_wdata = '0;   ib.req_wstrb = '0;   ib.rsp_ready = 1'b1;
  endtask

  // Present a request; returns at +1 after the accepting edge.
  task automatic send_a(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input logic st);
    int n = 0;
    bit ok = 1'b0;
    ia.req_valid = 1'b1; ia.req_write = wr; ia.req_addr = addr;
    ia.req_wdata = wd;   ia.req_wstrb = st;
    while (!ok && n < 50) begin
      #1;
      ok = (ia.req_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    ia.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_a addr=%0h: req_ready never rose within 50 cycles", addr);
    end
  endtask

  task automatic send_b(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] st);
    int n = 0;
    bit ok = 1'b0;
    ib.req_valid = 1'b1; ib.req_write = wr; ib.req_addr = addr;
    ib.req_wdata = wd;   ib.req_wstrb = st;
    while (!ok && n < 50) begin
      #1;
      ok = (ib.req_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    ib.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_b addr=%0h: req_ready never rose within 50 cycles", addr);
    end
  endtask

  // Read with 1-cycle latency check: response must be valid right after acceptance.
  task automatic read_a(input logic [7:0] addr, input logic [7:0] exp_d, input logic exp_e,
                        input string name);
    logic [8:0] e;
    q_a.push_back({exp_e, exp_d});
    send_a(1'b0, addr, 8'h00, 1'b0);
    e = q_a.pop_front();
    checks++;
    if (ia.rsp_valid !== 1'b1 || {ia.rsp_err, ia.rsp_rdata} !== e) begin
      errors++;
      $display("FAIL %s: got valid=%b err=%b data=%h, expected valid=1 err=%b data=%h",
               name, ia.rsp_valid, ia.rsp_err, ia.rsp_rdata, e[8], e[7:0]);
    end
  endtask

  task automatic read_b(input logic [7:0] addr, input logic [31:0] exp_d, input logic exp_e,
                        input string name);
    logic [32:0] e;
    q_b.push_back({exp_e, exp_d});
    send_b(1'b0, addr, 32'h0, 4'h0);
    e = q_b.pop_front();
    checks++;
    if (ib.rsp_valid !== 1'b1 || {ib.rsp_err, ib.rsp_rdata} !== e) begin
      errors++;
      $display("FAIL %s: got valid=%b err=%b data=%h, expected valid=1 err=%b data=%h",
               name, ib.rsp_valid, ib.rsp_err, ib.rsp_rdata, e[32], e[31:0]);
    end
  endtask

  // Count +1-sampled cycles with busy_a high, starting from the current sample.
  task automatic count_busy_a(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 1000) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    int b_cnt = 0;
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b1 || ia.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_ctrl: busy=%b req_ready=%b, expected 1 0", busy_a, ia.req_ready);
    end
    checks++;
    if (ia.rsp_valid !== 1'b0 || ia.rsp_rdata !== 8'h00 || ia.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_rsp: valid=%b data=%h err=%b, expected 0 00 0",
               ia.rsp_valid, ia.rsp_rdata, ia.rsp_err);
    end
    checks++;
    if (busy_b !== 1'b1 || ib.req_ready !== 1'b0 || ib.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: busy=%b req_ready=%b rsp_valid=%b, expected 1 0 0",
               busy_b, ib.req_ready, ib.rsp_valid);
    end
    rst_n = 1'b1;
    while (busy_a && cnt < 1000) begin
      if (busy_b) b_cnt++;
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL sweep_len_a: busy cycles=%0d, expected 256", cnt);
    end
    checks++;
    if (b_cnt != 200) begin
      errors++;
      $display("FAIL sweep_len_b: busy cycles=%0d, expected 200", b_cnt);
    end
    checks++;
    if (ia.req_ready !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_sweep: req_ready=%b busy=%b, expected 1 0",
               ia.req_ready, busy_a);
    end
  endtask

  task automatic test_init_values();
    read_a(8'd0,   8'hFF, 1'b0, "init_word0");
    read_a(8'd1,   8'h00, 1'b0, "init_word1");
    read_a(8'd255, 8'h00, 1'b0, "init_word255");
  endtask

  task automatic test_back_to_back();
    send_a(1'b1, 8'd20, 8'h96, 1'b1);
    read_a(8'd20, 8'h96, 1'b0, "raw_next_cycle");
    send_a(1'b1, 8'd20, 8'h00, 1'b0);
    read_a(8'd20, 8'h96, 1'b0, "strobe_off_keeps");
    read_a(8'd0,  8'hFF, 1'b0, "b2b_second_read");
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    @(posedge clk); #1;
    send_a(1'b1, 8'd3, 8'h5A, 1'b1);
    send_a(1'b1, 8'd4, 8'hC3, 1'b1);
    ia.rsp_ready = 1'b0;
    q_a.push_back({1'b0, 8'h5A});
    send_a(1'b0, 8'd3, 8'h00, 1'b0);
    q_a.push_back({1'b0, 8'hC3});
    ia.req_valid = 1'b1; ia.req_write = 1'b0; ia.req_addr = 8'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ia.req_ready !== 1'b0 || ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== q_a[0][7:0]) begin
        errors++;
        $display("FAIL hold_cycle%0d: req_ready=%b valid=%b data=%h, expected 0 1 %h",
                 i, ia.req_ready, ia.rsp_valid, ia.rsp_rdata, q_a[0][7:0]);
      end
      @(posedge clk); #1;
    end
    e = q_a.pop_front();
    ia.rsp_ready = 1'b1;
    #1;
    checks++;
    if (ia.req_ready !== 1'b1 || {ia.rsp_err, ia.rsp_rdata} !== e) begin
      errors++;
      $display("FAIL release_same_cycle: req_ready=%b data=%h, expected 1 %h",
               ia.req_ready, ia.rsp_rdata, e[7:0]);
    end
    @(posedge clk); #1;
    ia.req_valid = 1'b0;
    e = q_a.pop_front();
    checks++;
    if (ia.rsp_valid !== 1'b1 || {ia.rsp_err, ia.rsp_rdata} !== e) begin
      errors++;
      $display("FAIL replaced_rsp: valid=%b data=%h, expected 1 %h",
               ia.rsp_valid, ia.rsp_rdata, e[7:0]);
    end
  endtask

  task automatic test_wide_strobe();
    send_b(1'b1, 8'd5, 32'hAABBCCDD, 4'b1111);
    send_b(1'b1, 8'd5, 32'h11223344, 4'b0101);
    read_b(8'd5, 32'hAA22CC44, 1'b0, "wide_strobe_merge");
    read_b(8'd0, 32'hFFFFFFFF, 1'b0, "wide_init_word0");
  endtask

  task automatic test_out_of_range();
    send_b(1'b1, 8'd210, 32'h00000077, 4'b1111);
    read_b(8'd210, 32'h0, 1'b1, "oor_read_err");
    read_b(8'd10,  32'h0, 1'b0, "oor_no_alias10");
    read_b(8'd82,  32'h0, 1'b0, "oor_no_alias82");
    read_b(8'd199, 32'h0, 1'b0, "last_word_ok");
    send_b(1'b1, 8'd199, 32'h12345678, 4'b1111);
    read_b(8'd199, 32'h12345678, 1'b0, "last_word_write");
  endtask

  task automatic test_clear();
    int cnt = 0;
    logic [8:0] e;
    send_a(1'b1, 8'd7, 8'h33, 1'b1);
    @(posedge clk); #1;
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1; ia.req_write = 1'b0; ia.req_addr = 8'd7;
    clr_a = 1'b1;
    q_a.push_back({1'b0, 8'h33});
    #1;
    checks++;
    if (ia.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_accepts_req: req_ready=%b, expected 1", ia.req_ready);
    end
    @(posedge clk); #1;
    clr_a = 1'b0;
    ia.req_valid = 1'b0;
    while (busy_a && cnt < 1000) begin
      cnt++;
      if (cnt == 3) begin
        checks++;
        if (ia.rsp_valid !== 1'b1 || ia.rsp_rdata !== q_a[0][7:0]) begin
          errors++;
          $display("FAIL rsp_held_in_init: valid=%b data=%h, expected 1 %h",
                   ia.rsp_valid, ia.rsp_rdata, q_a[0][7:0]);
        end
      end
      if (cnt == 5) begin
        e = q_a.pop_front();
        checks++;
        if (ia.rsp_valid !== 1'b1 || {ia.rsp_err, ia.rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp_drain_in_init: valid=%b data=%h, expected 1 %h",
                   ia.rsp_valid, ia.rsp_rdata, e[7:0]);
        end
        ia.rsp_ready = 1'b1;
      end
      if (cnt == 50) clr_a = 1'b1;
      if (cnt == 51) clr_a = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL clear_sweep_len: busy cycles=%0d, expected 256", cnt);
    end
    read_a(8'd7, 8'h00, 1'b0, "clear_wipes_word7");
    read_a(8'd0, 8'hFF, 1'b0, "clear_restores_word0");
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    logic [8:0] e;
    @(posedge clk); #1;
    ia.rsp_ready = 1'b0;
    ia.req_valid = 1'b1; ia.req_write = 1'b0; ia.req_addr = 8'd0;
    clr_a = 1'b1;
    q_a.push_back({1'b0, 8'hFF});
    @(posedge clk); #1;
    clr_a = 1'b0;
    ia.req_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (ia.rsp_valid !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pending_before_reset: valid=%b busy=%b, expected 1 1",
               ia.rsp_valid, busy_a);
    end
    rst_n = 1'b0;
    #1;
    e = q_a.pop_front();
    checks++;
    if (ia.rsp_valid !== 1'b0 || busy_a !== 1'b1 || ia.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mid: valid=%b busy=%b req_ready=%b, expected 0 1 0 (dropped %h)",
               ia.rsp_valid, busy_a, ia.req_ready, e[7:0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ia.rsp_ready = 1'b1;
    count_busy_a(cnt);
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL restart_sweep_len: busy cycles=%0d, expected 256", cnt);
    end
    read_a(8'd0, 8'hFF, 1'b0, "after_reset_word0");
    read_a(8'd3, 8'h00, 1'b0, "after_reset_word3");
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_back_to_back();
    test_backpressure();
    test_wide_strobe();
    test_out_of_range();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
